// File: rtl/wb_ram_port_if.sv
// wb_ram_port_if: Wishbone classic slave-side bus bundle for wb_ram_port
interface wb_ram_port_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_ram_port.sv
// wb_ram_port: Wishbone classic slave fronting a byte-writable RAM macro, with optional zero-fill after reset
module wb_ram_port #(
  parameter int          ADDR_W         = 8,
  parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
  parameter logic [31:0] ADR_MASK       = 32'hFFFF_FC00,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_ram_port_if.slave      wbs,
  output logic              ram_en_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [31:0]       ram_di_o,
  output logic [3:0]        ram_we_o,
  input  logic [31:0]       ram_do_i,
  output logic              init_done_o
);
  typedef enum logic [1:0] {CLEAR, IDLE, RD_WAIT, ACK} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              init_done_q, init_done_d;
  logic              hit, clr, idle_hit;
  assign hit      = wbs.wbs_cyc_i & wbs.wbs_stb_i & ((wbs.wbs_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK));
  assign clr      = state_q == CLEAR;
  assign idle_hit = (state_q == IDLE) & hit;
  // RAM port: fill sequence owns the port during CLEAR, otherwise the bus drives it directly
  always_comb begin
    ram_en_o = clr | idle_hit;
    ram_we_o = clr ? 4'hF : (idle_hit & wbs.wbs_we_i) ? wbs.wbs_sel_i : 4'h0;
    ram_a_o  = clr ? clr_cnt_q : wbs.wbs_adr_i[ADDR_W+1:2];
    ram_di_o = clr ? 32'h0 : wbs.wbs_dat_i;
  end
  // Next state; ACK never looks at the request so a held strobe cannot double-write
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    dat_d       = dat_q;
    init_done_d = init_done_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE:    state_d = hit ? (wbs.wbs_we_i ? ACK : RD_WAIT) : IDLE;
      RD_WAIT: begin
        state_d = wbs.wbs_cyc_i ? ACK : IDLE;
        dat_d   = wbs.wbs_cyc_i ? ram_do_i : dat_q;
      end
      default: state_d = IDLE;
    endcase
    ack_d = state_d == ACK;
  end
  // State and output registers; reset restarts any fill from address 0
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt_q   <= '0;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
      init_done_q <= !CLEAR_ON_RESET;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      init_done_q <= init_done_d;
    end
  end
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign init_done_o   = init_done_q;
endmodule

// File: tb/tb_wb_ram_port.sv
// tb_wb_ram_port: scoreboard bench for wb_ram_port driving a behavioural RAM macro
module tb_wb_ram_port;
  localparam int ADDR_W = 8;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_a;
  logic [31:0]       ram_di;
  logic [3:0]        ram_we;
  logic [31:0]       ram_do;
  logic              init_done;
  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       ref_mem [2**ADDR_W];
  logic [ADDR_W-1:0] a_q = '0;
  logic [31:0]       exp_q [$];
  logic [31:0]       last_rd = 32'h0;
  int                n_chk = 0;
  int                n_err = 0;
  wb_ram_port_if bus ();
  wb_ram_port #(.ADDR_W(ADDR_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus.slave),
    .ram_en_o(ram_en), .ram_a_o(ram_a), .ram_di_o(ram_di), .ram_we_o(ram_we),
    .ram_do_i(ram_do), .init_done_o(init_done)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 2**ADDR_W; i++) mem[i] = $urandom | 32'h1;
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_a][8*b+:8] <= ram_di[8*b+:8];
      a_q <= ram_a;
    end
  end
  assign ram_do = mem[a_q];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
  endtask
  task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel, input int exp_lat);
    int lat = 0;
    logic [ADDR_W-1:0] w = adr[ADDR_W+1:2];
    if (we) begin
      for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[w][8*b+:8] = dat[8*b+:8];
    end else exp_q.push_back(ref_mem[w]);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel; bus.wbs_adr_i = adr; bus.wbs_dat_i = dat;
    do begin @(posedge clk); #1; lat++; end while (!bus.wbs_ack_o && lat < 400);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!we && exp_q.size() > 0) begin
      last_rd = exp_q.pop_front();
      chk({tag, "_dat"}, bus.wbs_dat_o, last_rd);
    end
    bus_idle();
    @(posedge clk); #1;
    chk({tag, "_ack_one_cycle"}, 32'(bus.wbs_ack_o), 32'h0);
  endtask
  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_init_cycles"}, 32'(n), 32'd256);
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
  endtask
  initial begin
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_init", 32'(init_done), 32'h0);
    @(negedge clk) rst = 1'b0;
    chk("clr_en", 32'(ram_en), 32'h1);
    chk("clr_we", 32'(ram_we), 32'hF);
    chk("clr_a0", 32'(ram_a), 32'h0);
    chk("clr_di", ram_di, 32'h0);
    wait_init("fill");
    xfer("rd_top", 1'b0, 32'h3000_03FC, 32'h0, 4'hF, 2);
    chk("rd_top_zero", last_rd, 32'h0);
    xfer("wr_beef", 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1);
    xfer("rd_beef", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 2);
    chk("rd_beef_const", bus.wbs_dat_o, 32'hDEAD_BEEF);
    xfer("wr_part", 1'b1, 32'h3000_0010, 32'h1122_3344, 4'b0101, 1);
    xfer("rd_part", 1'b0, 32'h3000_0011, 32'h0, 4'hF, 2);
    chk("rd_part_const", bus.wbs_dat_o, 32'hDE22_BE44);
    xfer("wr_sel0", 1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'h0, 1);
    chk("wr_sel0_keeps_dat", bus.wbs_dat_o, 32'hDE22_BE44);
    xfer("rd_sel0", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 2);
    chk("rd_sel0_const", bus.wbs_dat_o, 32'hDE22_BE44);
    xfer("wr_hi", 1'b1, 32'h3000_0200, 32'hA5A5_0F0F, 4'hF, 1);
    xfer("rd_hi", 1'b0, 32'h3000_0200, 32'h0, 4'hF, 2);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h3000_0400;
    bus.wbs_sel_i = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("miss_ack", 32'(bus.wbs_ack_o), 32'h0);
      chk("miss_en", 32'(ram_en), 32'h0);
    end
    bus_idle();
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h3000_0020;
    bus.wbs_sel_i = 4'hF;
    @(posedge clk); #1;
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_ack", 32'(bus.wbs_ack_o), 32'h0);
      chk("abort_dat", bus.wbs_dat_o, last_rd);
    end
    xfer("rd_after_abort", 1'b0, 32'h3000_0200, 32'h0, 4'hF, 2);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 100; i++) @(posedge clk);
    #1;
    chk("pulse_a100", 32'(ram_a), 32'd100);
    rst = 1'b1;
    #1;
    chk("pulse_a0", 32'(ram_a), 32'h0);
    chk("pulse_init", 32'(init_done), 32'h0);
    chk("pulse_ack", 32'(bus.wbs_ack_o), 32'h0);
    @(negedge clk) rst = 1'b0;
    wait_init("refill");
    xfer("rd_refill", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 2);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    xfer("rd_during_init", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 258);
    chk("rd_during_init_done", 32'(init_done), 32'h1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
